// File: rtl/ram_2r2w_pkg.sv
// Shared types and default constants for the dual-read / dual-write RAM controller.
package ram_2r2w_pkg;

    localparam int DEF_DATA_SIZE      = 16;
    localparam int DEF_RAM_DEPTH_LOG2 = 5;
    localparam logic [7:0] COLL_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_ISSUE = 2'd1,
        RD_RESP  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_2r2w_rd_chan.sv
// One read channel: request capture, RAM read issue and response hold.
// Build option RAM_2R2W_BYPASS_EN forwards same-cycle write data instead of stalling.
//
//   state    | meaning
//   RD_IDLE  | no read outstanding, ready for a request
//   RD_ISSUE | request registered, RAM read enable driven when no write hazard
//   RD_RESP  | response valid, data held until rsp handshake
module ram_2r2w_rd_chan
    import ram_2r2w_pkg::*;
#(
    parameter int DATA_SIZE      = DEF_DATA_SIZE,
    parameter int RAM_DEPTH_LOG2 = DEF_RAM_DEPTH_LOG2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_valid,
    output logic                      rd_ready,
    input  logic [RAM_DEPTH_LOG2-1:0] rd_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_SIZE-1:0]      rsp_data,
    output logic                      data_rden,
    output logic [RAM_DEPTH_LOG2-1:0] addr_rd,
    input  logic [DATA_SIZE-1:0]      data_out,
    input  logic                      wr_en1,
    input  logic [RAM_DEPTH_LOG2-1:0] wr_addr1,
    input  logic [DATA_SIZE-1:0]      wr_data1,
    input  logic                      wr_en2,
    input  logic [RAM_DEPTH_LOG2-1:0] wr_addr2,
    input  logic [DATA_SIZE-1:0]      wr_data2
);

    rd_state_t                 state_q, state_d;
    logic [RAM_DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [RAM_DEPTH_LOG2-1:0] addr_hold_q, addr_hold_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [DATA_SIZE-1:0]      rsp_data_q, rsp_data_d;

    logic                 hit1, hit2, stall, issue, accept;
    logic [DATA_SIZE-1:0] rd_word;

    assign hit1 = wr_en1 && (wr_addr1 == addr_q);
    assign hit2 = wr_en2 && (wr_addr2 == addr_q);

`ifdef RAM_2R2W_BYPASS_EN
    // Channel 2 has priority since it is the write that lands in the RAM.
    assign stall   = 1'b0;
    assign rd_word = hit2 ? wr_data2 : (hit1 ? wr_data1 : data_out);
`else
    logic unused_wr_data;
    assign unused_wr_data = ^{wr_data1, wr_data2};
    assign stall   = hit1 || hit2;
    assign rd_word = data_out;
`endif

    assign issue    = (state_q == RD_ISSUE) && !stall;
    assign rd_ready = reset_n && ((state_q == RD_IDLE) || ((state_q == RD_RESP) && rsp_ready));
    assign accept   = rd_valid && rd_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        addr_hold_d = addr_hold_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            RD_IDLE: begin
                if (accept) begin
                    addr_d  = rd_addr;
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (!stall) begin
                    rsp_data_d  = rd_word;
                    rsp_valid_d = 1'b1;
                    addr_hold_d = addr_q;
                    state_d     = RD_RESP;
                end
            end
            RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (accept) begin
                        addr_d  = rd_addr;
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            addr_hold_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            addr_hold_q <= addr_hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign data_rden = issue;
    assign addr_rd   = issue ? addr_q : addr_hold_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/ram_2r2w_ctrl.sv
// Controller for a 2-read/2-write RAM with async-read, sync-write timing.
// Build option RAM_2R2W_BYPASS_EN enables write-to-read forwarding in the read channels.
module ram_2r2w_ctrl
    import ram_2r2w_pkg::*;
#(
    parameter int DATA_SIZE      = DEF_DATA_SIZE,
    parameter int RAM_DEPTH_LOG2 = DEF_RAM_DEPTH_LOG2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_valid_1,
    output logic                      rd_ready_1,
    input  logic [RAM_DEPTH_LOG2-1:0] rd_addr_1,
    input  logic                      rd_valid_2,
    output logic                      rd_ready_2,
    input  logic [RAM_DEPTH_LOG2-1:0] rd_addr_2,
    output logic                      rsp_valid_1,
    input  logic                      rsp_ready_1,
    output logic [DATA_SIZE-1:0]      rsp_data_1,
    output logic                      rsp_valid_2,
    input  logic                      rsp_ready_2,
    output logic [DATA_SIZE-1:0]      rsp_data_2,
    input  logic                      wr_valid_1,
    output logic                      wr_ready_1,
    input  logic [RAM_DEPTH_LOG2-1:0] wr_addr_1,
    input  logic [DATA_SIZE-1:0]      wr_data_1,
    input  logic                      wr_valid_2,
    output logic                      wr_ready_2,
    input  logic [RAM_DEPTH_LOG2-1:0] wr_addr_2,
    input  logic [DATA_SIZE-1:0]      wr_data_2,
    output logic                      data_rden1,
    output logic                      data_rden2,
    output logic                      data_wren1,
    output logic                      data_wren2,
    output logic [RAM_DEPTH_LOG2-1:0] addr_in1rd,
    output logic [RAM_DEPTH_LOG2-1:0] addr_in2rd,
    output logic [RAM_DEPTH_LOG2-1:0] addr_in1wr,
    output logic [RAM_DEPTH_LOG2-1:0] addr_in2wr,
    output logic [DATA_SIZE-1:0]      data_in1,
    output logic [DATA_SIZE-1:0]      data_in2,
    input  logic [DATA_SIZE-1:0]      data_out1,
    input  logic [DATA_SIZE-1:0]      data_out2,
    output logic [7:0]                collision_cnt
);

    logic                      wr_vld1_q, wr_vld1_d, wr_vld2_q, wr_vld2_d;
    logic [RAM_DEPTH_LOG2-1:0] wr_addr1_q, wr_addr1_d, wr_addr2_q, wr_addr2_d;
    logic [DATA_SIZE-1:0]      wr_data1_q, wr_data1_d, wr_data2_q, wr_data2_d;
    logic [7:0]                coll_cnt_q, coll_cnt_d;
    logic                      same_addr;

    assign same_addr = wr_vld1_q && wr_vld2_q && (wr_addr1_q == wr_addr2_q);

    // Address/data registers only load on accept so the RAM pins hold their last values.
    always_comb begin
        wr_vld1_d  = wr_valid_1;
        wr_vld2_d  = wr_valid_2;
        wr_addr1_d = wr_addr1_q;
        wr_data1_d = wr_data1_q;
        wr_addr2_d = wr_addr2_q;
        wr_data2_d = wr_data2_q;
        coll_cnt_d = coll_cnt_q;
        if (wr_valid_1) begin
            wr_addr1_d = wr_addr_1;
            wr_data1_d = wr_data_1;
        end
        if (wr_valid_2) begin
            wr_addr2_d = wr_addr_2;
            wr_data2_d = wr_data_2;
        end
        if (same_addr && (coll_cnt_q != COLL_CNT_MAX)) begin
            coll_cnt_d = coll_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld1_q  <= 1'b0;
            wr_vld2_q  <= 1'b0;
            wr_addr1_q <= '0;
            wr_data1_q <= '0;
            wr_addr2_q <= '0;
            wr_data2_q <= '0;
            coll_cnt_q <= '0;
        end else begin
            wr_vld1_q  <= wr_vld1_d;
            wr_vld2_q  <= wr_vld2_d;
            wr_addr1_q <= wr_addr1_d;
            wr_data1_q <= wr_data1_d;
            wr_addr2_q <= wr_addr2_d;
            wr_data2_q <= wr_data2_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    assign wr_ready_1    = 1'b1;
    assign wr_ready_2    = 1'b1;
    assign data_wren1    = wr_vld1_q && !same_addr;
    assign data_wren2    = wr_vld2_q;
    assign addr_in1wr    = wr_addr1_q;
    assign addr_in2wr    = wr_addr2_q;
    assign data_in1      = wr_data1_q;
    assign data_in2      = wr_data2_q;
    assign collision_cnt = coll_cnt_q;

    ram_2r2w_rd_chan #(
        .DATA_SIZE      (DATA_SIZE),
        .RAM_DEPTH_LOG2 (RAM_DEPTH_LOG2)
    ) u_rd_chan_1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_valid  (rd_valid_1),
        .rd_ready  (rd_ready_1),
        .rd_addr   (rd_addr_1),
        .rsp_valid (rsp_valid_1),
        .rsp_ready (rsp_ready_1),
        .rsp_data  (rsp_data_1),
        .data_rden (data_rden1),
        .addr_rd   (addr_in1rd),
        .data_out  (data_out1),
        .wr_en1    (wr_vld1_q),
        .wr_addr1  (wr_addr1_q),
        .wr_data1  (wr_data1_q),
        .wr_en2    (wr_vld2_q),
        .wr_addr2  (wr_addr2_q),
        .wr_data2  (wr_data2_q)
    );

    ram_2r2w_rd_chan #(
        .DATA_SIZE      (DATA_SIZE),
        .RAM_DEPTH_LOG2 (RAM_DEPTH_LOG2)
    ) u_rd_chan_2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_valid  (rd_valid_2),
        .rd_ready  (rd_ready_2),
        .rd_addr   (rd_addr_2),
        .rsp_valid (rsp_valid_2),
        .rsp_ready (rsp_ready_2),
        .rsp_data  (rsp_data_2),
        .data_rden (data_rden2),
        .addr_rd   (addr_in2rd),
        .data_out  (data_out2),
        .wr_en1    (wr_vld1_q),
        .wr_addr1  (wr_addr1_q),
        .wr_data1  (wr_data1_q),
        .wr_en2    (wr_vld2_q),
        .wr_addr2  (wr_addr2_q),
        .wr_data2  (wr_data2_q)
    );

endmodule

// File: tb/tb_ram_2r2w_ctrl.sv
// Directed bench for ram_2r2w_ctrl with a behavioural async-read / sync-write RAM.
module tb_ram_2r2w_ctrl;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_valid_1, rd_ready_1, rd_valid_2, rd_ready_2;
    logic [AW-1:0] rd_addr_1, rd_addr_2;
    logic          rsp_valid_1, rsp_ready_1, rsp_valid_2, rsp_ready_2;
    logic [DW-1:0] rsp_data_1, rsp_data_2;
    logic          wr_valid_1, wr_ready_1, wr_valid_2, wr_ready_2;
    logic [AW-1:0] wr_addr_1, wr_addr_2;
    logic [DW-1:0] wr_data_1, wr_data_2;
    logic          data_rden1, data_rden2, data_wren1, data_wren2;
    logic [AW-1:0] addr_in1rd, addr_in2rd, addr_in1wr, addr_in2wr;
    logic [DW-1:0] data_in1, data_in2, data_out1, data_out2;
    logic [7:0]    collision_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: '0};

    always #5 clock = ~clock;

    // Port 1 written last so an unsuppressed colliding port-1 write would win here.
    always @(posedge clock) begin
        if (data_wren2) mem[addr_in2wr] <= data_in2;
        if (data_wren1) mem[addr_in1wr] <= data_in1;
    end
    assign data_out1 = mem[addr_in1rd];
    assign data_out2 = mem[addr_in2rd];

    ram_2r2w_ctrl #(.DATA_SIZE(DW), .RAM_DEPTH_LOG2(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .rd_valid_1(rd_valid_1), .rd_ready_1(rd_ready_1), .rd_addr_1(rd_addr_1),
        .rd_valid_2(rd_valid_2), .rd_ready_2(rd_ready_2), .rd_addr_2(rd_addr_2),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
        .rsp_valid_2(rsp_valid_2), .rsp_ready_2(rsp_ready_2), .rsp_data_2(rsp_data_2),
        .wr_valid_1(wr_valid_1), .wr_ready_1(wr_ready_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
        .wr_valid_2(wr_valid_2), .wr_ready_2(wr_ready_2), .wr_addr_2(wr_addr_2), .wr_data_2(wr_data_2),
        .data_rden1(data_rden1), .data_rden2(data_rden2),
        .data_wren1(data_wren1), .data_wren2(data_wren2),
        .addr_in1rd(addr_in1rd), .addr_in2rd(addr_in2rd),
        .addr_in1wr(addr_in1wr), .addr_in2wr(addr_in2wr),
        .data_in1(data_in1), .data_in2(data_in2),
        .data_out1(data_out1), .data_out2(data_out2),
        .collision_cnt(collision_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rd_valid_1 = 1'b0; rd_addr_1 = '0; rd_valid_2 = 1'b0; rd_addr_2 = '0;
        rsp_ready_1 = 1'b1; rsp_ready_2 = 1'b1;
        wr_valid_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0;
        wr_valid_2 = 1'b0; wr_addr_2 = '0; wr_data_2 = '0;

        // Reset state
        #2;
        chk("rst_rd_ready_1", 32'(rd_ready_1), 32'h0);
        chk("rst_rd_ready_2", 32'(rd_ready_2), 32'h0);
        chk("rst_rsp_valid_1", 32'(rsp_valid_1), 32'h0);
        chk("rst_wren", 32'({data_wren1, data_wren2, data_rden1, data_rden2}), 32'h0);
        chk("rst_addrs", 32'({addr_in1rd, addr_in2rd, addr_in1wr, addr_in2wr}), 32'h0);
        chk("rst_coll", 32'(collision_cnt), 32'h0);
        chk("wr_ready", 32'({wr_ready_1, wr_ready_2}), 32'h3);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("post_rst_rd_ready_1", 32'(rd_ready_1), 32'h1);
        chk("post_rst_rd_ready_2", 32'(rd_ready_2), 32'h1);

        // Write ch1 addr 3 then read it back
        wr_valid_1 = 1'b1; wr_addr_1 = 5'd3; wr_data_1 = 16'hA5A5;
        tick();
        chk("a_wren1", 32'(data_wren1), 32'h1);
        chk("a_addr_in1wr", 32'(addr_in1wr), 32'h3);
        chk("a_data_in1", 32'(data_in1), 32'hA5A5);
        wr_valid_1 = 1'b0;
        tick();
        chk("a_wren1_off", 32'(data_wren1), 32'h0);
        chk("a_mem3", 32'(mem[3]), 32'hA5A5);
        rd_valid_1 = 1'b1; rd_addr_1 = 5'd3;
        tick();
        rd_valid_1 = 1'b0;
        chk("a_rden1", 32'(data_rden1), 32'h1);
        chk("a_addr_in1rd", 32'(addr_in1rd), 32'h3);
        chk("a_rsp_valid_early", 32'(rsp_valid_1), 32'h0);
        tick();
        chk("a_rsp_valid", 32'(rsp_valid_1), 32'h1);
        chk("a_rsp_data", 32'(rsp_data_1), 32'hA5A5);
        chk("a_rden1_resp", 32'(data_rden1), 32'h0);
        tick();
        chk("a_rsp_done", 32'(rsp_valid_1), 32'h0);

        // Same-address write collision, read back on ch2
        wr_valid_1 = 1'b1; wr_addr_1 = 5'd7; wr_data_1 = 16'h1111;
        wr_valid_2 = 1'b1; wr_addr_2 = 5'd7; wr_data_2 = 16'h2222;
        tick();
        chk("b_wren1_suppr", 32'(data_wren1), 32'h0);
        chk("b_wren2", 32'(data_wren2), 32'h1);
        chk("b_data_in2", 32'(data_in2), 32'h2222);
        chk("b_coll_pre", 32'(collision_cnt), 32'h0);
        wr_valid_1 = 1'b0; wr_valid_2 = 1'b0;
        rd_valid_2 = 1'b1; rd_addr_2 = 5'd7;
        tick();
        rd_valid_2 = 1'b0;
        chk("b_coll", 32'(collision_cnt), 32'h1);
        chk("b_mem7", 32'(mem[7]), 32'h2222);
        chk("b_rden2", 32'(data_rden2), 32'h1);
        chk("b_addr_in2rd", 32'(addr_in2rd), 32'h7);
        tick();
        chk("b_rsp_valid_2", 32'(rsp_valid_2), 32'h1);
        chk("b_rsp_data_2", 32'(rsp_data_2), 32'h2222);
        tick();
        chk("b_rsp_done_2", 32'(rsp_valid_2), 32'h0);

        // Read of addr 5 issuing together with a write of 0xBEEF to addr 5
        rd_valid_1 = 1'b1; rd_addr_1 = 5'd5;
        wr_valid_2 = 1'b1; wr_addr_2 = 5'd5; wr_data_2 = 16'hBEEF;
        tick();
        rd_valid_1 = 1'b0; wr_valid_2 = 1'b0;
`ifdef RAM_2R2W_BYPASS_EN
        chk("c_rden1_byp", 32'(data_rden1), 32'h1);
        tick();
        chk("c_rsp_valid_t2", 32'(rsp_valid_1), 32'h1);
        chk("c_rsp_data_t2", 32'(rsp_data_1), 32'hBEEF);
`else
        chk("c_rden1_stall", 32'(data_rden1), 32'h0);
        chk("c_addr_hold", 32'(addr_in1rd), 32'h3);
        tick();
        chk("c_rsp_valid_t2", 32'(rsp_valid_1), 32'h0);
        chk("c_rden1_late", 32'(data_rden1), 32'h1);
        chk("c_addr_in1rd", 32'(addr_in1rd), 32'h5);
        tick();
        chk("c_rsp_valid_t3", 32'(rsp_valid_1), 32'h1);
        chk("c_rsp_data_t3", 32'(rsp_data_1), 32'hBEEF);
`endif
        tick();
        chk("c_rsp_done", 32'(rsp_valid_1), 32'h0);

        // Response back-pressure for 4 cycles, then handshake with a new request
        rd_valid_1 = 1'b1; rd_addr_1 = 5'd3;
        tick();
        rd_valid_1 = 1'b0; rsp_ready_1 = 1'b0;
        chk("d_rden1", 32'(data_rden1), 32'h1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("d_hold_valid", 32'(rsp_valid_1), 32'h1);
            chk("d_hold_data", 32'(rsp_data_1), 32'hA5A5);
            chk("d_hold_rd_ready", 32'(rd_ready_1), 32'h0);
            chk("d_hold_rden", 32'(data_rden1), 32'h0);
            if (i == 0) begin
                wr_valid_2 = 1'b1; wr_addr_2 = 5'd3; wr_data_2 = 16'h5555;
                rd_valid_1 = 1'b1; rd_addr_1 = 5'd7;
            end else begin
                wr_valid_2 = 1'b0;
            end
            tick();
        end
        rsp_ready_1 = 1'b1;
        #1;
        chk("d_rd_ready_resp", 32'(rd_ready_1), 32'h1);
        tick();
        rd_valid_1 = 1'b0;
        chk("d_mem3", 32'(mem[3]), 32'h5555);
        chk("d_rsp_valid_gap", 32'(rsp_valid_1), 32'h0);
        chk("d_rden1_next", 32'(data_rden1), 32'h1);
        chk("d_addr_next", 32'(addr_in1rd), 32'h7);
        tick();
        chk("d_rsp_valid_next", 32'(rsp_valid_1), 32'h1);
        chk("d_rsp_data_next", 32'(rsp_data_1), 32'h2222);
        tick();
        chk("d_rsp_done", 32'(rsp_valid_1), 32'h0);

        // Reset asserted while a read and a write are in their issue cycle
        rd_valid_1 = 1'b1; rd_addr_1 = 5'd7;
        wr_valid_1 = 1'b1; wr_addr_1 = 5'd9; wr_data_1 = 16'hDEAD;
        tick();
        rd_valid_1 = 1'b0; wr_valid_1 = 1'b0;
        chk("e_wren1_pre", 32'(data_wren1), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("e_wren1", 32'(data_wren1), 32'h0);
        chk("e_rden1", 32'(data_rden1), 32'h0);
        chk("e_rd_ready_1", 32'(rd_ready_1), 32'h0);
        chk("e_addr_data", 32'({addr_in1wr, addr_in1rd, data_in1}), 32'h0);
        chk("e_coll", 32'(collision_cnt), 32'h0);
        tick();
        chk("e_mem9", 32'(mem[9]), 32'h0);
        chk("e_rsp_valid", 32'(rsp_valid_1), 32'h0);
        reset_n = 1'b1;
        #1;
        chk("e_rd_ready_rel", 32'(rd_ready_1), 32'h1);
        tick();
        chk("e_rsp_valid_after", 32'(rsp_valid_1), 32'h0);
        chk("e_mem9_after", 32'(mem[9]), 32'h0);

        // 300 colliding write pairs saturate the counter
        wr_valid_1 = 1'b1; wr_addr_1 = 5'd4; wr_data_1 = 16'h1234;
        wr_valid_2 = 1'b1; wr_addr_2 = 5'd4; wr_data_2 = 16'h4321;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 255) chk("f_coll_254", 32'(collision_cnt), 32'd254);
            if (k == 256) chk("f_coll_255", 32'(collision_cnt), 32'd255);
        end
        wr_valid_1 = 1'b0; wr_valid_2 = 1'b0;
        tick(); tick();
        chk("f_coll_sat", 32'(collision_cnt), 32'd255);
        chk("f_mem4", 32'(mem[4]), 32'h4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_2r2w_ctrl.md
RAM_2R2W_CTRL -- requirements
Module: ram_2r2w_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16, data word width.
REQ-002 SHALL have parameter RAM_DEPTH_LOG2, default 5, address width.
REQ-003 SHALL have port clock  in  1  sole clock, all state on posedge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports rd_valid_n / rd_ready_n  in/out  1  read-request handshake, n=1,2.
REQ-006 SHALL have port rd_addr_n  in  RAM_DEPTH_LOG2  read address, n=1,2.
REQ-007 SHALL have ports rsp_valid_n / rsp_ready_n  out/in  1  read-response handshake, n=1,2.
REQ-008 SHALL have port rsp_data_n  out  DATA_SIZE  read data, n=1,2.
REQ-009 SHALL have ports wr_valid_n / wr_ready_n  in/out  1  write-request handshake, n=1,2.
REQ-010 SHALL have ports wr_addr_n / wr_data_n  in  RAM_DEPTH_LOG2 / DATA_SIZE  write address/data, n=1,2.
REQ-011 SHALL have ports data_rden1/2, data_wren1/2  out  1  RAM port enables.
REQ-012 SHALL have ports addr_in1rd/2rd/1wr/2wr  out  RAM_DEPTH_LOG2  RAM addresses.
REQ-013 SHALL have ports data_in1/2 out and data_out1/2 in, each DATA_SIZE, RAM write/read data.
REQ-014 SHALL have port collision_cnt  out  8  saturating count of same-address write collisions.

Function
REQ-015 SHALL register every accepted request (valid & ready) and drive the matching RAM signals in the next cycle only (issue cycle); enables are low in all other cycles.
REQ-016 SHALL keep wr_ready_n high always; a write accepted at T writes the RAM at posedge ending T+1.
REQ-017 SHALL implement a per-channel read FSM IDLE -> ISSUE -> RESP; rd_ready_n high only in IDLE or in RESP with rsp_ready_n high; one outstanding read per channel.
REQ-018 SHALL transition ISSUE -> RESP after one cycle with data_rdenN high; RESP -> ISSUE on rsp handshake plus new accepted request, RESP -> IDLE on rsp handshake alone.
REQ-019 SHALL assert rsp_valid_n only in RESP, rsp_data_n stable until handshake; minimum latency accept T -> rsp_valid T+2.
REQ-020 SHALL, when both writes issue to the same address in one cycle, suppress data_wren1 so channel 2 wins, and increment collision_cnt, saturating at 255.
REQ-021 SHALL keep address and data outputs at their last values when enables are low.

Reset
REQ-022 SHALL on reset_n low immediately force all enables, rsp_valid_n, rd_ready_n and addresses/data outputs to 0, FSMs to IDLE, collision_cnt to 0.
REQ-023 SHALL drop any in-flight request on reset mid-operation; no RAM write occurs after reset asserts.
REQ-024 SHALL raise rd_ready_n in the first cycle after reset_n deasserts.

Configuration
REQ-025 SHALL with RAM_2R2W_BYPASS_EN defined, when a read issues to an address written in the same issue cycle, return the written data (channel-2 data if both write it) as rsp_data_n.
REQ-026 SHALL without RAM_2R2W_BYPASS_EN, hold the read in ISSUE with data_rdenN low for each cycle a write to its address issues, issuing the read in the first cycle with no conflict.

Structure
REQ-027 SHALL place FSM state encoding and default parameter constants in shared package ram_2r2w_pkg.
REQ-028 SHALL implement the read FSM as sub-module ram_2r2w_rd_chan, instantiated twice.

Verification
REQ-029 SHALL cover: write ch1 addr 3 data 0xA5A5, then read ch1 addr 3 -> rsp_data_1 = 0xA5A5 at T+2.
REQ-030 SHALL cover: both channels write addr 7 (0x1111, 0x2222) same cycle -> RAM holds 0x2222, collision_cnt = 1.
REQ-031 SHALL cover: read addr 5 issuing with write 0xBEEF to addr 5 -> bypass build returns 0xBEEF at T+2; non-bypass build returns 0xBEEF at T+3.
REQ-032 SHALL cover: rsp_ready_1 low 4 cycles -> rsp_data_1 stable, rd_ready_1 low, data_rden1 low.
REQ-033 SHALL cover: reset_n low during ISSUE -> outputs 0 that cycle, no rsp_valid, RAM content unchanged by pending write.
REQ-034 SHALL cover: 300 colliding write pairs -> collision_cnt = 255.
